// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer-to-VGA scanner: cell grid,
// 640x480@60 raster geometry and the 12-bit colour type.
package fb_pkg;

  localparam int FB_COLS    = 40;
  localparam int FB_ROWS    = 30;
  localparam int FB_BITS    = FB_COLS * FB_ROWS;
  localparam int CELL_SHIFT = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      color_t;
  typedef logic [10:0]      cell_idx_t;

  // Linear framebuffer index of a cell: row-major, FB_COLS cells per row.
  function automatic cell_idx_t cell_index(input logic [4:0] row, input logic [5:0] col);
    cell_idx_t row_w;
    cell_idx_t col_w;
    row_w = {6'd0, row};
    col_w = {5'd0, col};
    return (row_w * cell_idx_t'(FB_COLS)) + col_w;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and raster counters. Sync and active flags are plain
// decodes of the current (pre-increment) counter position.
module vga_timing
  import fb_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int HVIS    = H_VISIBLE,
  parameter int HFP     = H_FP,
  parameter int HSW     = H_SYNC,
  parameter int HBP     = H_BP,
  parameter int VVIS    = V_VISIBLE,
  parameter int VFP     = V_FP,
  parameter int VSW     = V_SYNC,
  parameter int VBP     = V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pixel_en_o,
  output cnt_t h_o,
  output cnt_t v_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic active_o
);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  localparam cnt_t H_LAST     = cnt_t'(HVIS + HFP + HSW + HBP - 1);
  localparam cnt_t H_SYNC_LO  = cnt_t'(HVIS + HFP);
  localparam cnt_t H_SYNC_HI  = cnt_t'(HVIS + HFP + HSW - 1);
  localparam cnt_t H_VIS_END  = cnt_t'(HVIS);

  localparam cnt_t V_LAST     = cnt_t'(VVIS + VFP + VSW + VBP - 1);
  localparam cnt_t V_SYNC_LO  = cnt_t'(VVIS + VFP);
  localparam cnt_t V_SYNC_HI  = cnt_t'(VVIS + VFP + VSW - 1);
  localparam cnt_t V_VIS_END  = cnt_t'(VVIS);

  logic [1:0] div_q, div_d;
  cnt_t       h_q, h_d;
  cnt_t       v_q, v_d;
  logic       pixel_en;

  assign pixel_en = (div_q == DIV_LAST);

  // Divider restarts on each tick; the raster advances only on ticks.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (pixel_en) begin
      div_d = 2'd0;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      div_d = div_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= 2'd0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pixel_en_o = pixel_en;
  assign h_o        = h_q;
  assign v_o        = v_q;
  assign hsync_o    = (h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI);
  assign vsync_o    = (v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI);
  assign active_o   = (h_q < H_VIS_END) && (v_q < V_VIS_END);

endmodule

// File: rtl/fb_vga_scanner.sv
// Scans a 40x30 monochrome framebuffer out as 16x16-pixel cells on VGA.
// The framebuffer is latched once per frame at the start of vertical blanking.
module fb_vga_scanner
  import fb_pkg::*;
#(
  parameter int     CLK_DIV  = 2,
  parameter color_t FG_COLOR = 12'hFFF,
  parameter color_t BG_COLOR = 12'h000,
  parameter int     HVIS     = H_VISIBLE,
  parameter int     HFP      = H_FP,
  parameter int     HSW      = H_SYNC,
  parameter int     HBP      = H_BP,
  parameter int     VVIS     = V_VISIBLE,
  parameter int     VFP      = V_FP,
  parameter int     VSW      = V_SYNC,
  parameter int     VBP      = V_BP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FB_BITS-1:0] framebuffer,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_done
);

  localparam cnt_t      SNAP_LINE = cnt_t'(VVIS);
  localparam cell_idx_t IDX_LIMIT = cell_idx_t'(FB_BITS);

  logic      pixel_en;
  cnt_t      h_cnt;
  cnt_t      v_cnt;
  logic      hsync_raw;
  logic      vsync_raw;
  logic      active;
  cell_idx_t idx;
  logic      cell_on;
  logic      snap_take;

  logic [FB_BITS-1:0] snapshot_q, snapshot_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  color_t             rgb_q, rgb_d;
  logic               frame_done_q, frame_done_d;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .HVIS    (HVIS),
    .HFP     (HFP),
    .HSW     (HSW),
    .HBP     (HBP),
    .VVIS    (VVIS),
    .VFP     (VFP),
    .VSW     (VSW),
    .VBP     (VBP)
  ) u_timing (
    .clk_i      (clock),
    .rst_i      (reset),
    .pixel_en_o (pixel_en),
    .h_o        (h_cnt),
    .v_o        (v_cnt),
    .hsync_o    (hsync_raw),
    .vsync_o    (vsync_raw),
    .active_o   (active)
  );

  assign idx       = cell_index(v_cnt[CELL_SHIFT +: 5], h_cnt[CELL_SHIFT +: 6]);
  assign snap_take = pixel_en && (h_cnt == 10'd0) && (v_cnt == SNAP_LINE);

  // Index is only meaningful inside the active area; guard it elsewhere.
  always_comb begin
    cell_on = 1'b0;
    if (idx < IDX_LIMIT) begin
      cell_on = snapshot_q[idx];
    end else begin
      cell_on = 1'b0;
    end
  end

  // Output stage samples the pre-increment raster position on each tick so
  // sync and colour share the same one-tick latency.
  always_comb begin
    snapshot_d   = snapshot_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    rgb_d        = rgb_q;
    frame_done_d = snap_take;
    if (snap_take) begin
      snapshot_d = framebuffer;
    end else begin
      snapshot_d = snapshot_q;
    end
    if (pixel_en) begin
      hs_d = !hsync_raw;
      vs_d = !vsync_raw;
      if (active) begin
        rgb_d = cell_on ? FG_COLOR : BG_COLOR;
      end else begin
        rgb_d = 12'h000;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snapshot_q   <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      rgb_q        <= 12'h000;
      frame_done_q <= 1'b0;
    end else begin
      snapshot_q   <= snapshot_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign frame_done = frame_done_q;

endmodule
